btb_predictor: RTL and testbench
================================

// Module: btb_predictor
// PURPOSE
//  Direct-mapped branch target buffer with 2-bit saturating counters. Predicts taken/target for the
//  fetch PC each cycle. Trained by the resolved outcome from the EX branch unit (taken, target, is_jump).
//  Registers a one-cycle mispredict/redirect pulse back to fetch and the pipeline flush logic.
// PARAMETERS
//  XLEN     riscv_pkg  data/address width (32)
//  ENTRIES  64         BTB entries; power of 2, >=4
//  IDX_W    $clog2(ENTRIES)  derived, not overridable
// PORTS
//  clk              in   1     clock, rising edge
//  rst              in   1     async reset, active-high
//  if_pc            in   XLEN  fetch PC to look up
//  pred_taken       out  1     prediction: redirect fetch to pred_target
//  pred_target      out  XLEN  predicted target (0 when pred_taken=0)
//  upd_valid        in   1     EX has a resolved, non-killed control instr this cycle
//  upd_pc           in   XLEN  PC of that instr
//  upd_is_branch    in   1     conditional branch
//  upd_is_jump      in   1     JAL/JALR
//  upd_taken        in   1     resolved taken (branch_taken from EX)
//  upd_target       in   XLEN  resolved target (branch_target from EX)
//  upd_pred_taken   in   1     prediction carried down the pipe with the instr
//  upd_pred_target  in   XLEN  predicted target carried down the pipe
//  mispredict       out  1     registered 1-cycle pulse: prediction wrong
//  redirect_pc      out  XLEN  registered correct next PC, valid with mispredict
// BEHAVIOUR
//  Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. pc[1:0] ignored.
//  Entry = {valid, tag, target[XLEN-1:0], ctr[1:0]}.
//  Lookup is combinational from the array: hit = valid && tag match.
//   pred_taken = hit && ctr[1]; pred_target = pred_taken ? target : 0.
//  Update on posedge clk when upd_valid && (upd_is_branch || upd_is_jump):
//   - Miss, taken: allocate (overwrite). valid=1, tag, target=upd_target, ctr=2'b10 (branch) or 2'b11 (jump).
//   - Miss, not taken: no write.
//   - Hit, taken: ctr = sat_inc (max 3); target = upd_target.
//   - Hit, not taken: ctr = sat_dec (min 0); target and valid unchanged.
//   - upd_is_branch=upd_is_jump=0 with upd_valid=1: no write, no mispredict.
//  Mispredict (registered, latency 1 after upd_valid):
//   - Flagged if upd_taken != upd_pred_taken, or upd_taken && upd_target != upd_pred_target.
//   - redirect_pc = upd_taken ? upd_target : upd_pc + 4 (mod 2^XLEN wrap).
//   - Outputs drop to 0 the next cycle unless a new mispredicting update arrives.
//  Same-cycle lookup and update of one index: lookup returns pre-update contents.
//  Reset (async, any time): all valid=0, ctr=0, mispredict=0, redirect_pc=0.
//   pred_taken=0 and pred_target=0 immediately. Target/tag storage is not reset.
//  Pipeline must deassert upd_valid for flushed instrs. No back-pressure; an update is accepted every cycle.
// CONFIGURATION
//  BTB_STATS_EN defined: adds outputs
//   stat_lookups   out  32  counts valid update events.
//   stat_mispred   out  32  counts mispredict pulses.
//   Both saturate at 32'hFFFF_FFFF. Async reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Reset, if_pc sweeps 0x0..0x3FC -> pred_taken=0, pred_target=0 for all; mispredict=0.
//  2. Update taken branch pc=0x100, target=0x80, pred_taken=0:
//     next cycle mispredict=1, redirect_pc=0x80; if_pc=0x100 -> pred_taken=1, pred_target=0x80.
//  3. Then two not-taken updates at 0x100 (pred_taken=1):
//     ctr 2->1->0; each cycle mispredict=1, redirect_pc=0x104; lookup 0x100 -> pred_taken=0.
//  4. Alias: entry at 0x100 valid; if_pc=0x100+ENTRIES*4 -> pred_taken=0.
//     Taken update there replaces the entry; 0x100 then misses.
//  5. JALR at 0x200: pred target 0x300, resolved 0x340, both taken -> mispredict=1, redirect_pc=0x340;
//     entry target updated to 0x340. Same-cycle lookup of 0x200 returns 0x300.
//  6. Assert rst mid-stream with mispredict=1 -> mispredict, redirect_pc, pred_taken=0 asynchronously;
//     with BTB_STATS_EN, counters read 0.

Source files
------------

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters and a registered mispredict/redirect pulse.
// Optional statistics counters are compiled in when BTB_STATS_EN is defined.
module btb_predictor #(
    parameter  int XLEN    = 32,
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_branch,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
`ifdef BTB_STATS_EN
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_mispred,
`endif
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0]  tgt_q   [ENTRIES];

    logic             mispredict_q, mispredict_d;
    logic [XLEN-1:0]  redirect_q, redirect_d;

    // Lookup path: reads pre-update contents even when indexing the entry being written.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             unused_lsbs;

    assign lk_idx      = if_pc[IDX_W+1:2];
    assign lk_tag      = if_pc[XLEN-1:IDX_W+2];
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target = pred_taken ? tgt_q[lk_idx] : '0;
    assign unused_lsbs = ^if_pc[1:0];

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_act, upd_hit;
    logic             ctr_we, tgt_we;
    logic [1:0]       ctr_d;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_W+2];
    assign upd_act = upd_valid && (upd_is_branch || upd_is_jump);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign ctr_we  = upd_act && (upd_hit || upd_taken);
    assign tgt_we  = upd_act && upd_taken;

    always_comb begin
        ctr_d = ctr_q[upd_idx];
        if (!upd_hit) begin
            ctr_d = upd_is_jump ? 2'b11 : 2'b10;
        end else if (upd_taken) begin
            if (ctr_q[upd_idx] != 2'b11) ctr_d = ctr_q[upd_idx] + 2'd1;
        end else begin
            if (ctr_q[upd_idx] != 2'b00) ctr_d = ctr_q[upd_idx] - 2'd1;
        end
    end

    always_comb begin
        mispredict_d = upd_act && ((upd_taken != upd_pred_taken) ||
                                   (upd_taken && (upd_target != upd_pred_target)));
        redirect_d   = '0;
        if (mispredict_d)
            redirect_d = upd_taken ? upd_target : (upd_pc + {{(XLEN-3){1'b0}}, 3'd4});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            if (ctr_we) ctr_q[upd_idx] <= ctr_d;
            if (tgt_we) valid_q[upd_idx] <= 1'b1;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
        end
    end

    // Tag and target payload carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (tgt_we) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= upd_target;
        end
    end

    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_q;

`ifdef BTB_STATS_EN
    logic [31:0] lookups_q, mispred_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            if (upd_act && (lookups_q != 32'hFFFF_FFFF))      lookups_q <= lookups_q + 32'd1;
            if (mispredict_d && (mispred_q != 32'hFFFF_FFFF)) mispred_q <= mispred_q + 32'd1;
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_mispred = mispred_q;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed-vector bench for btb_predictor: lookup, training, aliasing, JALR retarget, wrap and async reset.
module tb_btb_predictor;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_pred_taken;
    logic [XLEN-1:0] upd_pc, upd_target, upd_pred_target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
`ifdef BTB_STATS_EN
    logic [31:0]     stat_lookups, stat_mispred;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    btb_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_is_branch   (upd_is_branch),
        .upd_is_jump     (upd_is_jump),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
`ifdef BTB_STATS_EN
        .stat_lookups    (stat_lookups),
        .stat_mispred    (stat_mispred),
`endif
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [XLEN-1:0] pc,
                        input logic exp_tk, input logic [XLEN-1:0] exp_tgt);
        if_pc = pc;
        #1;
        chk({tag, ".tk"},  64'(pred_taken),  64'(exp_tk));
        chk({tag, ".tgt"}, 64'(pred_target), 64'(exp_tgt));
    endtask

    // Present one update across a rising edge, then drop upd_valid.
    task automatic upd(input logic [XLEN-1:0] pc, input logic br, input logic jmp,
                       input logic tk, input logic [XLEN-1:0] tgt,
                       input logic ptk, input logic [XLEN-1:0] ptgt);
        upd_pc = pc; upd_is_branch = br; upd_is_jump = jmp;
        upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
        upd_valid = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic chk_mp(input string tag, input logic exp_mp, input logic [XLEN-1:0] exp_rd);
        chk({tag, ".mp"}, 64'(mispredict),  64'(exp_mp));
        chk({tag, ".rd"}, 64'(redirect_pc), 64'(exp_rd));
    endtask

    initial begin
        rst = 1'b1; if_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_is_branch = 1'b0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        #1;
        chk_mp("rst", 1'b0, 32'h0);
        #11 rst = 1'b0;

        // 1: empty table never predicts
        for (int pc = 0; pc <= 32'h3FC; pc += 4) look("sweep", 32'(pc), 1'b0, 32'h0);
        chk_mp("idle", 1'b0, 32'h0);

        // 2: allocate taken branch at 0x100
        if_pc = 32'h100; #1;
        chk("pre_alloc.tk", 64'(pred_taken), 64'd0);
        upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h0);
        chk_mp("alloc", 1'b1, 32'h80);
        look("alloc", 32'h100, 1'b1, 32'h80);
        @(posedge clk); #1;
        chk_mp("pulse_drop", 1'b0, 32'h0);

        // 3: train down to 0, saturate, then back up
        upd(32'h100, 1, 0, 0, 32'h0, 1, 32'h80);
        chk_mp("nt1", 1'b1, 32'h104);
        look("nt1", 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1, 0, 0, 32'h0, 1, 32'h80);
        chk_mp("nt2", 1'b1, 32'h104);
        look("nt2", 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1, 0, 0, 32'h0, 0, 32'h0);
        chk_mp("nt_sat", 1'b0, 32'h0);
        upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h0);
        chk_mp("tk_from0", 1'b1, 32'h80);
        look("ctr1", 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h0);
        look("ctr2", 32'h100, 1'b1, 32'h80);

        // 4: alias at 0x100 + ENTRIES*4 replaces the entry
        look("alias_miss", 32'h200, 1'b0, 32'h0);
        upd(32'h200, 1, 0, 1, 32'h500, 0, 32'h0);
        look("alias_new", 32'h200, 1'b1, 32'h500);
        look("alias_old", 32'h100, 1'b0, 32'h0);

        // 5: JALR retarget, same-cycle lookup sees old target
        upd(32'h200, 0, 1, 1, 32'h300, 1, 32'h500);
        chk_mp("jalr_a", 1'b1, 32'h300);
        upd_pc = 32'h200; upd_is_branch = 0; upd_is_jump = 1; upd_taken = 1;
        upd_target = 32'h340; upd_pred_taken = 1; upd_pred_target = 32'h300;
        upd_valid = 1'b1; if_pc = 32'h200; #1;
        chk("jalr_same.tgt", 64'(pred_target), 64'h300);
        @(posedge clk); #1; upd_valid = 1'b0;
        chk_mp("jalr_b", 1'b1, 32'h340);
        look("jalr_b", 32'h200, 1'b1, 32'h340);

        // ctr at 3 stays 3 on a correct taken update, then decays 3->2->1
        upd(32'h200, 1, 0, 1, 32'h340, 1, 32'h340);
        chk_mp("correct", 1'b0, 32'h0);
        upd(32'h200, 1, 0, 0, 32'h0, 1, 32'h340);
        chk_mp("top_nt1", 1'b1, 32'h204);
        look("ctr3to2", 32'h200, 1'b1, 32'h340);
        upd(32'h200, 1, 0, 0, 32'h0, 1, 32'h340);
        look("ctr2to1", 32'h200, 1'b0, 32'h0);

        // jump allocates strongly taken
        upd(32'h48, 0, 1, 1, 32'h1000, 0, 32'h0);
        upd(32'h48, 0, 1, 0, 32'h0, 1, 32'h1000);
        look("jal_alloc3", 32'h48, 1'b1, 32'h1000);

        // miss not-taken and non-control updates write nothing
        upd(32'h40, 1, 0, 0, 32'h0, 0, 32'h0);
        chk_mp("miss_nt", 1'b0, 32'h0);
        upd(32'h40, 0, 0, 1, 32'h900, 0, 32'h0);
        chk_mp("non_ctl", 1'b0, 32'h0);
        look("non_ctl", 32'h40, 1'b0, 32'h0);

        // fall-through wraps modulo 2^XLEN
        upd(32'hFFFF_FFFC, 1, 0, 0, 32'h0, 1, 32'h10);
        chk_mp("wrap", 1'b1, 32'h0);

        // 6: async reset while a mispredict pulse is live
        upd(32'h48, 0, 1, 1, 32'h2000, 0, 32'h0);
        if_pc = 32'h48;
        chk_mp("pre_rst", 1'b1, 32'h2000);
        #2 rst = 1'b1;
        #1;
        chk_mp("async_rst", 1'b0, 32'h0);
        chk("async_rst.tk",  64'(pred_taken),  64'd0);
        chk("async_rst.tgt", 64'(pred_target), 64'd0);
`ifdef BTB_STATS_EN
        chk("stat_lookups", 64'(stat_lookups), 64'd0);
        chk("stat_mispred", 64'(stat_mispred), 64'd0);
`endif
        #10 rst = 1'b0;
        look("post_rst", 32'h200, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
